// File: rtl/stream_demux4_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package stream_demux4_pkg;

  localparam int CH_NUM     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int STAT_W     = 16;

  localparam logic [1:0] FIFO_FULL = 2'd2;

  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t CH0 = 2'b00;
  localparam ch_sel_t CH1 = 2'b01;
  localparam ch_sel_t CH2 = 2'b10;
  localparam ch_sel_t CH3 = 2'b11;

  // Saturating increment for the delivered-word statistics.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry per-channel FIFO; head word is read straight from the storage registers.
module demux_chan_fifo
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FIFO_FULL);
  assign empty     = (count_r == 2'd0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 valid/ready stream demultiplexer with a 2-entry buffer per channel.
// Optional per-channel delivered-word counters are enabled by STREAM_DEMUX4_STATS_EN.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  ch_sel_t            in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [CH_NUM-1:0]  out_valid,
  input  logic [CH_NUM-1:0]  out_ready,
  output logic [WIDTH-1:0]   out_data0,
  output logic [WIDTH-1:0]   out_data1,
  output logic [WIDTH-1:0]   out_data2,
  output logic [WIDTH-1:0]   out_data3
`ifdef STREAM_DEMUX4_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_cnt0,
  output logic [STAT_W-1:0]  stat_cnt1,
  output logic [STAT_W-1:0]  stat_cnt2,
  output logic [STAT_W-1:0]  stat_cnt3
`endif
);

  logic [CH_NUM-1:0] push_s;
  logic [CH_NUM-1:0] pop_s;
  logic [CH_NUM-1:0] full_s;
  logic [CH_NUM-1:0] empty_s;
  logic [WIDTH-1:0]  head_s [CH_NUM];

  // in_ready only looks at registered full flags, keeping out_ready off this path.
  always_comb begin
    in_ready = 1'b0;
    push_s   = '0;
    case (in_sel)
      CH0: begin
        in_ready  = ~full_s[0];
        push_s[0] = in_valid & ~full_s[0];
      end
      CH1: begin
        in_ready  = ~full_s[1];
        push_s[1] = in_valid & ~full_s[1];
      end
      CH2: begin
        in_ready  = ~full_s[2];
        push_s[2] = in_valid & ~full_s[2];
      end
      CH3: begin
        in_ready  = ~full_s[3];
        push_s[3] = in_valid & ~full_s[3];
      end
      default: begin
        in_ready = 1'b0;
        push_s   = '0;
      end
    endcase
  end

  assign pop_s     = out_ready & ~empty_s;
  assign out_valid = ~empty_s;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    demux_chan_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .wdata (in_data),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .head  (head_s[g])
    );
  end

  assign out_data0 = head_s[0];
  assign out_data1 = head_s[1];
  assign out_data2 = head_s[2];
  assign out_data3 = head_s[3];

`ifdef STREAM_DEMUX4_STATS_EN
  logic [STAT_W-1:0] stat_r [CH_NUM];

  // Per-channel delivered-word counters, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        stat_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (pop_s[i]) begin
          stat_r[i] <= sat_inc(stat_r[i]);
        end else begin
          stat_r[i] <= stat_r[i];
        end
      end
    end
  end

  assign stat_cnt0 = stat_r[0];
  assign stat_cnt1 = stat_r[1];
  assign stat_cnt2 = stat_r[2];
  assign stat_cnt3 = stat_r[3];
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Scoreboard bench for stream_demux4: driver queues expected words, a negedge monitor checks pops.
module tb_stream_demux4;
  import stream_demux4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  ch_sel_t    in_sel;
  logic [7:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
`ifdef STREAM_DEMUX4_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q [4][$];
  logic [7:0]  od [4];
  logic [15:0] pop_cnt [4];

  always #5 clk = ~clk;

  stream_demux4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef STREAM_DEMUX4_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_cnt3 (stat_cnt3)
`endif
  );

  always_comb begin
    od[0] = out_data0;
    od[1] = out_data1;
    od[2] = out_data2;
    od[3] = out_data3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on an output channel must match the queued word.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) pop_cnt[k] = 16'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word ch%0d: got %0h expected none", k, od[k]);
          end else begin
            chk($sformatf("data_ch%0d", k), {24'd0, od[k]}, {24'd0, exp_q[k].pop_front()});
          end
          if (pop_cnt[k] != 16'hFFFF) pop_cnt[k] = pop_cnt[k] + 16'd1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input ch_sel_t sel, input logic [7:0] d, input logic exp_acc);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
    if (exp_acc) exp_q[sel].push_back(d);
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = 8'h00;
    out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data", {out_data0, out_data1, out_data2, out_data3}, 32'd0);
`ifdef STREAM_DEMUX4_STATS_EN
    chk("reset_stat", {stat_cnt0 | stat_cnt1, stat_cnt2 | stat_cnt3}, 32'd0);
`endif
    rst_n = 1'b1;
    cyc();

    // Single word, first-edge latency and pop on the following edge.
    send(CH2, 8'hA5, 1'b1);
    chk("a5_out_valid", {28'd0, out_valid}, 32'h4);
    chk("a5_out_data2", {24'd0, out_data2}, 32'hA5);
    cyc();
    chk("a5_popped", {28'd0, out_valid}, 32'h0);

    // Fill channel 1, third word refused; other channels still open.
    out_ready = 4'b0000;
    send(CH1, 8'h11, 1'b1);
    send(CH1, 8'h22, 1'b1);
    send(CH1, 8'h33, 1'b0);
    chk("ch1_full_valid", {28'd0, out_valid}, 32'h2);
    send(CH3, 8'h44, 1'b1);
    chk("ch3_while_ch1_full", {28'd0, out_valid}, 32'hA);
    chk("ch1_head_kept", {24'd0, out_data1}, 32'h11);

    // Release channel 1 while holding 33: one bubble cycle before it is accepted.
    out_ready = 4'b0010;
    in_valid  = 1'b1;
    in_sel    = CH1;
    in_data   = 8'h33;
    #1;
    chk("ch1_ready_before_pop", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("ch1_ready_after_pop", {31'd0, in_ready}, 32'd1);
    exp_q[1].push_back(8'h33);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("ch1_drained", {28'd0, out_valid}, 32'h8);
    out_ready = 4'b1000;
    cyc();
    chk("ch3_drained", {28'd0, out_valid}, 32'h0);

    // Sustained throughput while alternating channels.
    out_ready = 4'b1111;
    send(CH0, 8'h01, 1'b1);
    send(CH1, 8'h02, 1'b1);
    send(CH2, 8'h03, 1'b1);
    send(CH3, 8'h04, 1'b1);
    send(CH0, 8'h05, 1'b1);
    send(CH0, 8'h06, 1'b1);
    cyc();
    chk("alt_drained", {28'd0, out_valid}, 32'h0);

    // Simultaneous push and pop at count 1 on channel 0.
    out_ready = 4'b0000;
    send(CH0, 8'h77, 1'b1);
    out_ready = 4'b0001;
    send(CH0, 8'h55, 1'b1);
    chk("pp_out_valid", {28'd0, out_valid}, 32'h1);
    chk("pp_new_head", {24'd0, out_data0}, 32'h55);
    out_ready = 4'b0000;
    send(CH0, 8'h66, 1'b1);
    send(CH0, 8'h99, 1'b0);
    send(CH3, 8'h88, 1'b1);

    // Asynchronous reset mid-transfer discards buffered words.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_data", {out_data0, out_data1, out_data2, out_data3}, 32'd0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    cyc();
    repeat (4) cyc();
    chk("post_rst_idle", {28'd0, out_valid}, 32'h0);

`ifdef STREAM_DEMUX4_STATS_EN
    chk("post_rst_stat0", {16'd0, stat_cnt0}, 32'd0);
    for (int i = 0; i < 65534; i++) send(CH2, i[7:0], 1'b1);
    cyc();
    chk("stat2_near_max", {16'd0, stat_cnt2}, 32'hFFFE);
    for (int i = 0; i < 3; i++) send(CH2, i[7:0], 1'b1);
    cyc();
    chk("stat2_saturated", {16'd0, stat_cnt2}, 32'hFFFF);
    chk("stat2_model", {16'd0, stat_cnt2}, {16'd0, pop_cnt[2]});
    chk("stat1_zero", {16'd0, stat_cnt1}, 32'd0);
`endif

    for (int k = 0; k < 4; k++) chk($sformatf("queue_empty_ch%0d", k), exp_q[k].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
